// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package arc_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } fetchState_t;

    localparam int          INSTR_BYTES          = 4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam int          CNT_WIDTH            = 3;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Decode handshake, redirect and memory bus signals of the fetch stage.
interface instruction_fetch_unit_if #(
    parameter int DATAWIDTH_BUS = 32
);
    logic                     Fetch_Enable_In;
    logic                     Fetch_Redirect_In;
    logic [DATAWIDTH_BUS-1:0] Fetch_RedirectAddr_In;
    logic                     Fetch_Ready_In;
    logic                     Fetch_Valid_Out;
    logic [DATAWIDTH_BUS-1:0] Fetch_Instr_Out;
    logic [DATAWIDTH_BUS-1:0] Fetch_PC_Out;
    logic [DATAWIDTH_BUS-1:0] Fetch_MemAddress_Out;
    logic                     Fetch_MemRD_Out;
    logic [DATAWIDTH_BUS-1:0] Fetch_MemData_In;
    logic [1:0]               Fetch_State_Out;

    modport master (
        input  Fetch_Enable_In, Fetch_Redirect_In, Fetch_RedirectAddr_In,
               Fetch_Ready_In, Fetch_MemData_In,
        output Fetch_Valid_Out, Fetch_Instr_Out, Fetch_PC_Out,
               Fetch_MemAddress_Out, Fetch_MemRD_Out, Fetch_State_Out
    );

    modport slave (
        output Fetch_Enable_In, Fetch_Redirect_In, Fetch_RedirectAddr_In,
               Fetch_Ready_In, Fetch_MemData_In,
        input  Fetch_Valid_Out, Fetch_Instr_Out, Fetch_PC_Out,
               Fetch_MemAddress_Out, Fetch_MemRD_Out, Fetch_State_Out
    );

endinterface

// File: rtl/instruction_fetch_unit_wait_counter.sv
// Loadable down-counter timing the memory latency; stops at zero.
module fetch_wait_counter
    import arc_fetch_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 dec,
    input  logic [CNT_WIDTH-1:0] loadValue,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= loadValue;
        end else if (dec && !zero) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: issues PC to memory, waits the latency, holds the word for decode.
//   state | meaning
//   IDLE  | no fetch outstanding, memory read off
//   ISSUE | address presented, latency counter freshly loaded
//   WAIT  | address held, counting down remaining latency
//   HOLD  | captured word presented to decode until accepted
module instruction_fetch_unit
    import arc_fetch_pkg::*;
#(
    parameter int                       DATAWIDTH_BUS = 32,
    parameter logic [DATAWIDTH_BUS-1:0] RESET_VECTOR  = DEFAULT_RESET_VECTOR,
    parameter int                       MEM_LATENCY   = 1
) (
    input  logic                            CLOCK_50,
    input  logic                            RESET_InHigh,
    instruction_fetch_unit_if.master        bus
);

    if (MEM_LATENCY < 1 || MEM_LATENCY > 7) begin : gBadLatency
        $error("instruction_fetch_unit: MEM_LATENCY must be within 1..7");
    end

    localparam logic [CNT_WIDTH-1:0]     LOAD_VALUE = CNT_WIDTH'(MEM_LATENCY - 1);
    localparam logic [DATAWIDTH_BUS-1:0] PC_STEP    = DATAWIDTH_BUS'(INSTR_BYTES);
    localparam logic [DATAWIDTH_BUS-1:0] ALIGN_MASK = ~DATAWIDTH_BUS'(INSTR_BYTES - 1);

    fetchState_t              state;
    fetchState_t              stateNext;
    logic [DATAWIDTH_BUS-1:0] pc;
    logic [DATAWIDTH_BUS-1:0] redirectPc;
    logic [DATAWIDTH_BUS-1:0] issueAddr;
    logic [DATAWIDTH_BUS-1:0] instrReg;
    logic [DATAWIDTH_BUS-1:0] pcOutReg;
    logic [DATAWIDTH_BUS-1:0] memAddrReg;
    logic                     validReg;
    logic                     memRdReg;
    logic                     cntLoad;
    logic                     cntDec;
    logic                     cntZero;
    logic [CNT_WIDTH-1:0]     cntValue;

    assign redirectPc = bus.Fetch_RedirectAddr_In & ALIGN_MASK;

    always_comb begin
        stateNext = state;
        issueAddr = pc;
        if (bus.Fetch_Redirect_In) begin
            stateNext = bus.Fetch_Enable_In ? ISSUE : IDLE;
            issueAddr = redirectPc;
        end else begin
            case (state)
                IDLE:        if (bus.Fetch_Enable_In) stateNext = ISSUE;
                ISSUE, WAIT: stateNext = cntZero ? HOLD : WAIT;
                HOLD:        if (bus.Fetch_Ready_In)
                                 stateNext = bus.Fetch_Enable_In ? ISSUE : IDLE;
                default:     stateNext = IDLE;
            endcase
        end
    end

    // Every entry into ISSUE (including a redirect re-issue) restarts the latency count.
    assign cntLoad = (stateNext == ISSUE);
    assign cntDec  = (state == ISSUE || state == WAIT) && !bus.Fetch_Redirect_In;

    fetch_wait_counter uWaitCounter (
        .clk       (CLOCK_50),
        .rst       (RESET_InHigh),
        .load      (cntLoad),
        .dec       (cntDec),
        .loadValue (LOAD_VALUE),
        .count     (cntValue),
        .zero      (cntZero)
    );

    always_ff @(posedge CLOCK_50 or posedge RESET_InHigh) begin
        if (RESET_InHigh) begin
            state      <= IDLE;
            pc         <= RESET_VECTOR;
            validReg   <= 1'b0;
            instrReg   <= '0;
            pcOutReg   <= '0;
            memRdReg   <= 1'b0;
            memAddrReg <= RESET_VECTOR;
        end else begin
            state    <= stateNext;
            memRdReg <= (stateNext == ISSUE) || (stateNext == WAIT);
            if (stateNext == ISSUE) begin
                memAddrReg <= issueAddr;
            end

            // A redirect abandons whatever is in flight, so its data is never captured.
            if (bus.Fetch_Redirect_In) begin
                pc       <= redirectPc;
                validReg <= 1'b0;
            end else begin
                case (state)
                    ISSUE, WAIT: begin
                        if (cntZero) begin
                            instrReg <= bus.Fetch_MemData_In;
                            pcOutReg <= pc;
                            pc       <= pc + PC_STEP;
                            validReg <= 1'b1;
                        end
                    end
                    HOLD: begin
                        if (bus.Fetch_Ready_In) begin
                            validReg <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.Fetch_Valid_Out      = validReg;
    assign bus.Fetch_Instr_Out      = instrReg;
    assign bus.Fetch_PC_Out         = pcOutReg;
    assign bus.Fetch_MemAddress_Out = memAddrReg;
    assign bus.Fetch_MemRD_Out      = memRdReg;
    assign bus.Fetch_State_Out      = state;

endmodule
